// File: rtl/ads7883_emu.sv
// ADS7883 serial responder: shifts {2'b00, D[11:0], 2'b00} on sclk falls; D from sample_data or internal ramp.
// Optional build macro ADS7883_EMU_SYNC_EN adds two-flop input synchronizers (+2 cycles latency).
module ads7883_emu #(
   parameter logic [11:0] RAMP_STEP = 12'd1,
   parameter logic [11:0] RAMP_INIT = 12'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ads7883_sclk,
   input  logic        ads7883_ncs,
   input  logic [11:0] sample_data,
   input  logic        pat_mode,
   output logic        ads7883_sdo,
   output logic        sdo_oe,
   output logic        sample_req,
   output logic        frame_done,
   output logic        frame_abort,
   output logic [15:0] frame_cnt,
   output logic [7:0]  abort_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

   logic sclk_in, ncs_in;

`ifdef ADS7883_EMU_SYNC_EN
   logic [1:0] sclk_sync, ncs_sync;
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= 2'b00;
         ncs_sync  <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[0], ads7883_sclk};
         ncs_sync  <= {ncs_sync[0], ads7883_ncs};
      end
   end
   assign sclk_in = sclk_sync[1];
   assign ncs_in  = ncs_sync[1];
`else
   assign sclk_in = ads7883_sclk;
   assign ncs_in  = ads7883_ncs;
`endif

   // Sampled copy plus one-cycle-delayed copy; zero at reset so a held-low line never reads as a fall.
   logic sclk_cur, sclk_prev, ncs_cur, ncs_prev;
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_cur  <= 1'b0;
         sclk_prev <= 1'b0;
         ncs_cur   <= 1'b0;
         ncs_prev  <= 1'b0;
      end else begin
         sclk_cur  <= sclk_in;
         sclk_prev <= sclk_cur;
         ncs_cur   <= ncs_in;
         ncs_prev  <= ncs_cur;
      end
   end

   logic sclk_fall, ncs_fall, ncs_rise;
   assign sclk_fall = sclk_prev & ~sclk_cur;
   assign ncs_fall  = ncs_prev & ~ncs_cur;
   assign ncs_rise  = ~ncs_prev & ncs_cur;

   state_t      state_q, state_d;
   logic [3:0]  bit_idx_q, bit_idx_d, next_idx;
   logic [15:0] word_q, word_d;
   logic [11:0] ramp_q, ramp_d;
   logic        sdo_d, oe_d, req_d, done_d, abort_d;
   logic [15:0] fcnt_d;
   logic [7:0]  acnt_d;

   assign next_idx = bit_idx_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      word_d    = word_q;
      ramp_d    = ramp_q;
      sdo_d     = ads7883_sdo;
      oe_d      = sdo_oe;
      req_d     = 1'b0;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      fcnt_d    = frame_cnt;
      acnt_d    = abort_cnt;
      case (state_q)
         IDLE: begin
            if (ncs_fall) begin
               word_d    = {2'b00, (pat_mode ? ramp_q : sample_data), 2'b00};
               bit_idx_d = 4'd0;
               sdo_d     = word_d[15];
               oe_d      = 1'b1;
               req_d     = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Completion outranks a coincident ncs rise; the rise then sends us straight to IDLE.
            if (sclk_fall && bit_idx_q == 4'd15) begin
               done_d  = 1'b1;
               fcnt_d  = frame_cnt + 16'd1;
               ramp_d  = ramp_q + RAMP_STEP;
               oe_d    = 1'b0;
               sdo_d   = 1'b0;
               state_d = ncs_rise ? IDLE : QUIET;
            end else if (ncs_rise) begin
               abort_d = 1'b1;
               acnt_d  = (abort_cnt == 8'hFF) ? abort_cnt : abort_cnt + 8'd1;
               oe_d    = 1'b0;
               sdo_d   = 1'b0;
               state_d = IDLE;
            end else if (sclk_fall) begin
               bit_idx_d = next_idx;
               sdo_d     = word_q[4'd15 - next_idx];
            end
         end
         QUIET: begin
            if (ncs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_idx_q   <= 4'd0;
         word_q      <= 16'd0;
         ramp_q      <= RAMP_INIT;
         ads7883_sdo <= 1'b0;
         sdo_oe      <= 1'b0;
         sample_req  <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         frame_cnt   <= 16'd0;
         abort_cnt   <= 8'd0;
      end else begin
         bit_idx_q   <= bit_idx_d;
         word_q      <= word_d;
         ramp_q      <= ramp_d;
         ads7883_sdo <= sdo_d;
         sdo_oe      <= oe_d;
         sample_req  <= req_d;
         frame_done  <= done_d;
         frame_abort <= abort_d;
         frame_cnt   <= fcnt_d;
         abort_cnt   <= acnt_d;
      end
   end

endmodule
